// File: rtl/barrel_shift_seq.sv
// Command sequencer feeding a combinational barrel shifter: one accepted command
// is replayed for len+1 beats, with the shift amount stepping by one (mod 2^SW) per beat.
module barrel_shift_seq #(
    parameter int DW = 4,
    parameter int SW = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [DW-1:0] i_cmd_data,
    input  logic          i_cmd_left,
    input  logic [SW-1:0] i_cmd_shift,
    input  logic [SW-1:0] i_cmd_len,
    output logic          o_left,
    output logic [SW-1:0] o_shift,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    output logic          o_last,
    input  logic          i_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic          left_q, left_d;
    logic [SW-1:0] shift_q, shift_d;
    logic [SW-1:0] len_q, len_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            left_q  <= 1'b0;
            shift_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            left_q  <= left_d;
            shift_q <= shift_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // o_last is precomputed one edge ahead so every output stays a pure register.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        left_d  = left_q;
        shift_d = shift_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    state_d = RUN;
                    data_d  = i_cmd_data;
                    left_d  = i_cmd_left;
                    shift_d = i_cmd_shift;
                    len_d   = i_cmd_len;
                    cnt_d   = '0;
                    last_d  = (i_cmd_len == '0);
                end
            end
            RUN: begin
                if (i_ready) begin
                    shift_d = shift_q + 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_q) begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                    end else begin
                        last_d = ((cnt_q + 1'b1) == len_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_cmd_ready = (state_q == IDLE);
    assign o_valid     = (state_q == RUN);
    assign o_last      = last_q;
    assign o_left      = left_q;
    assign o_shift     = shift_q;
    assign o_data      = data_q;

endmodule

// File: tb/tb_barrel_shift_seq.sv
// Directed bench for barrel_shift_seq: inputs change and outputs are checked on
// the falling edge, so every check sees the state settled after the previous rising edge.
module tb_barrel_shift_seq;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [3:0] i_cmd_data;
    logic       i_cmd_left;
    logic [1:0] i_cmd_shift;
    logic [1:0] i_cmd_len;
    logic       o_left;
    logic [1:0] o_shift;
    logic [3:0] o_data;
    logic       o_valid;
    logic       o_last;
    logic       i_ready;

    int vectors = 0;
    int misses  = 0;

    barrel_shift_seq #(.DW(4), .SW(2)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_data  (i_cmd_data),
        .i_cmd_left  (i_cmd_left),
        .i_cmd_shift (i_cmd_shift),
        .i_cmd_len   (i_cmd_len),
        .o_left      (o_left),
        .o_shift     (o_shift),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_last      (o_last),
        .i_ready     (i_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic drive_cmd(input logic [3:0] d, input logic l, input logic [1:0] s, input logic [1:0] n);
        i_cmd_valid = 1'b1;
        i_cmd_data  = d;
        i_cmd_left  = l;
        i_cmd_shift = s;
        i_cmd_len   = n;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_ready = 1'b1;
        drive_cmd(4'b1111, 1'b1, 2'd3, 2'd3);
        tick();
        tick();
        vectors++;
        if (o_cmd_ready !== 1'b1) begin misses++; $display("[TB] FAIL reset_cmd_ready got %b want 1", o_cmd_ready); end
        vectors++;
        if (o_valid !== 1'b0) begin misses++; $display("[TB] FAIL reset_valid got %b want 0", o_valid); end
        vectors++;
        if (o_shift !== 2'd0) begin misses++; $display("[TB] FAIL reset_shift got %0d want 0", o_shift); end
        vectors++;
        if (o_last !== 1'b0 || o_data !== 4'b0000 || o_left !== 1'b0) begin
            misses++; $display("[TB] FAIL reset_outputs got last=%b data=%b left=%b want 0/0000/0", o_last, o_data, o_left);
        end
        i_rst = 1'b0;
        i_cmd_valid = 1'b0;
        tick();
        vectors++;
        if (o_valid !== 1'b0) begin misses++; $display("[TB] FAIL reset_no_accept got valid=%b want 0", o_valid); end
    endtask

    task automatic test_single_beat();
        drive_cmd(4'b1011, 1'b1, 2'd2, 2'd0);
        tick();
        i_cmd_valid = 1'b0;
        vectors++;
        if (o_valid !== 1'b1 || o_shift !== 2'd2 || o_last !== 1'b1 || o_data !== 4'b1011 || o_left !== 1'b1 || o_cmd_ready !== 1'b0) begin
            misses++;
            $display("[TB] FAIL single_beat got v=%b sh=%0d last=%b d=%b l=%b rdy=%b want 1 2 1 1011 1 0",
                     o_valid, o_shift, o_last, o_data, o_left, o_cmd_ready);
        end
        tick();
        vectors++;
        if (o_valid !== 1'b0 || o_last !== 1'b0 || o_cmd_ready !== 1'b1) begin
            misses++; $display("[TB] FAIL single_done got v=%b last=%b rdy=%b want 0 0 1", o_valid, o_last, o_cmd_ready);
        end
    endtask

    task automatic test_full_sweep();
        logic [1:0] expShift [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
        drive_cmd(4'b0110, 1'b0, 2'd3, 2'd3);
        i_ready = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (o_valid !== 1'b1 || o_shift !== expShift[i] || o_last !== (i == 3) || o_data !== 4'b0110 || o_left !== 1'b0) begin
                misses++;
                $display("[TB] FAIL sweep_beat%0d got v=%b sh=%0d last=%b d=%b l=%b want 1 %0d %0d 0110 0",
                         i, o_valid, o_shift, o_last, o_data, o_left, expShift[i], (i == 3));
            end
            tick();
        end
        vectors++;
        if (o_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin
            misses++; $display("[TB] FAIL sweep_done got v=%b rdy=%b want 0 1", o_valid, o_cmd_ready);
        end
    endtask

    task automatic test_backpressure();
        drive_cmd(4'b1001, 1'b1, 2'd0, 2'd2);
        i_ready = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        vectors++;
        if (o_valid !== 1'b1 || o_shift !== 2'd0 || o_last !== 1'b0) begin
            misses++; $display("[TB] FAIL bp_beat0 got v=%b sh=%0d last=%b want 1 0 0", o_valid, o_shift, o_last);
        end
        tick();
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (o_valid !== 1'b1 || o_shift !== 2'd1 || o_last !== 1'b0 || o_data !== 4'b1001 || o_left !== 1'b1) begin
                misses++;
                $display("[TB] FAIL bp_stall%0d got v=%b sh=%0d last=%b d=%b l=%b want 1 1 0 1001 1",
                         i, o_valid, o_shift, o_last, o_data, o_left);
            end
            tick();
        end
        vectors++;
        if (o_valid !== 1'b1 || o_shift !== 2'd1 || o_last !== 1'b0) begin
            misses++; $display("[TB] FAIL bp_held got v=%b sh=%0d last=%b want 1 1 0", o_valid, o_shift, o_last);
        end
        i_ready = 1'b1;
        tick();
        vectors++;
        if (o_valid !== 1'b1 || o_shift !== 2'd2 || o_last !== 1'b1) begin
            misses++; $display("[TB] FAIL bp_beat2 got v=%b sh=%0d last=%b want 1 2 1", o_valid, o_shift, o_last);
        end
        tick();
        vectors++;
        if (o_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin
            misses++; $display("[TB] FAIL bp_done got v=%b rdy=%b want 0 1", o_valid, o_cmd_ready);
        end
    endtask

    task automatic test_cmd_during_run();
        drive_cmd(4'b0101, 1'b1, 2'd1, 2'd2);
        i_ready = 1'b1;
        tick();
        drive_cmd(4'b1100, 1'b0, 2'd0, 2'd0);
        vectors++;
        if (o_cmd_ready !== 1'b0 || o_data !== 4'b0101 || o_shift !== 2'd1) begin
            misses++; $display("[TB] FAIL busy_beat0 got rdy=%b d=%b sh=%0d want 0 0101 1", o_cmd_ready, o_data, o_shift);
        end
        tick();
        vectors++;
        if (o_cmd_ready !== 1'b0 || o_data !== 4'b0101 || o_left !== 1'b1 || o_shift !== 2'd2) begin
            misses++; $display("[TB] FAIL busy_beat1 got rdy=%b d=%b l=%b sh=%0d want 0 0101 1 2", o_cmd_ready, o_data, o_left, o_shift);
        end
        tick();
        vectors++;
        if (o_shift !== 2'd3 || o_last !== 1'b1 || o_data !== 4'b0101) begin
            misses++; $display("[TB] FAIL busy_beat2 got sh=%0d last=%b d=%b want 3 1 0101", o_shift, o_last, o_data);
        end
        tick();
        vectors++;
        if (o_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin
            misses++; $display("[TB] FAIL busy_gap got v=%b rdy=%b want 0 1", o_valid, o_cmd_ready);
        end
        tick();
        i_cmd_valid = 1'b0;
        vectors++;
        if (o_valid !== 1'b1 || o_data !== 4'b1100 || o_left !== 1'b0 || o_shift !== 2'd0 || o_last !== 1'b1) begin
            misses++;
            $display("[TB] FAIL busy_next got v=%b d=%b l=%b sh=%0d last=%b want 1 1100 0 0 1",
                     o_valid, o_data, o_left, o_shift, o_last);
        end
        tick();
        vectors++;
        if (o_valid !== 1'b0) begin misses++; $display("[TB] FAIL busy_next_done got v=%b want 0", o_valid); end
    endtask

    task automatic test_midrun_reset();
        drive_cmd(4'b1110, 1'b1, 2'd1, 2'd3);
        i_ready = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        vectors++;
        if (o_valid !== 1'b1 || o_shift !== 2'd1) begin
            misses++; $display("[TB] FAIL mr_beat0 got v=%b sh=%0d want 1 1", o_valid, o_shift);
        end
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        vectors++;
        if (o_valid !== 1'b0 || o_last !== 1'b0 || o_shift !== 2'd0 || o_cmd_ready !== 1'b1) begin
            misses++; $display("[TB] FAIL mr_reset got v=%b last=%b sh=%0d rdy=%b want 0 0 0 1", o_valid, o_last, o_shift, o_cmd_ready);
        end
        drive_cmd(4'b0011, 1'b0, 2'd2, 2'd1);
        tick();
        i_cmd_valid = 1'b0;
        vectors++;
        if (o_valid !== 1'b1 || o_shift !== 2'd2 || o_last !== 1'b0 || o_data !== 4'b0011) begin
            misses++; $display("[TB] FAIL mr_new0 got v=%b sh=%0d last=%b d=%b want 1 2 0 0011", o_valid, o_shift, o_last, o_data);
        end
        tick();
        vectors++;
        if (o_valid !== 1'b1 || o_shift !== 2'd3 || o_last !== 1'b1) begin
            misses++; $display("[TB] FAIL mr_new1 got v=%b sh=%0d last=%b want 1 3 1", o_valid, o_shift, o_last);
        end
        tick();
        vectors++;
        if (o_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin
            misses++; $display("[TB] FAIL mr_done got v=%b rdy=%b want 0 1", o_valid, o_cmd_ready);
        end
    endtask

    initial begin
        i_rst       = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_data  = '0;
        i_cmd_left  = 1'b0;
        i_cmd_shift = '0;
        i_cmd_len   = '0;
        i_ready     = 1'b0;
        tick();
        test_reset();
        test_single_beat();
        test_full_sweep();
        test_backpressure();
        test_cmd_during_run();
        test_midrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule

// File: doc/barrel_shift_seq.md
Name: barrel_shift_seq

Overview:
Upstream command sequencer that drives the combinational barrel shifter (left, shift, i_data inputs). It accepts one shift command over a valid/ready handshake and replays the data word over N consecutive beats, stepping the shift amount by one each beat with modulo wrap. Each beat is presented as a registered left/shift/data triple with its own valid/ready handshake toward the consumer of the shifter output. It is used to sweep shift amounts for datapath testing and for multi-step shift sequences.

Parameters:
DW, 4, data width; must equal the barrel shifter data width
SW, 2, shift-amount width; equals log2(DW)

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  synchronous reset, active-high
i_cmd_valid  input  1  command present
o_cmd_ready  output  1  sequencer can accept a command
i_cmd_data  input  DW  data word to be shifted
i_cmd_left  input  1  direction: 1 = left, 0 = right
i_cmd_shift  input  SW  first-beat shift amount
i_cmd_len  input  SW  beat count minus 1 (N = i_cmd_len+1, range 1..2^SW)
o_left  output  1  to barrel shifter left
o_shift  output  SW  to barrel shifter shift
o_data  output  DW  to barrel shifter i_data
o_valid  output  1  current beat valid
o_last  output  1  current beat is final beat of the command
i_ready  input  1  downstream accepts current beat

Behaviour:
- Decided: one clock (i_clk); reset i_rst is synchronous and active-high.
- Reset values: o_cmd_ready=1, o_valid=0, o_last=0, o_left=0, o_shift=0, o_data=0; internal beat counter=0; state=IDLE.
- States: IDLE, RUN.
- IDLE: o_cmd_ready=1, o_valid=0. On i_cmd_valid=1, capture data/left/shift/len and go to RUN on the next edge. First beat valid on the cycle after acceptance (1-cycle latency).
- RUN: o_cmd_ready=0. o_valid=1. o_data and o_left are held constant for the whole command. The beat counter counts completed beats from 0.
- Beat transfer occurs when o_valid and i_ready are both 1. On transfer: o_shift <= o_shift+1 mod 2^SW (3 wraps to 0); beat counter +1.
- o_last=1 when beat counter == captured len. A transfer with o_last=1 returns the block to IDLE: o_valid=0, o_last=0, o_cmd_ready=1 on the next cycle. The next command is not accepted on the same edge (no back-to-back acceptance; one idle cycle minimum between commands).
- Backpressure: with i_ready=0, all outputs hold exactly their values (o_shift, o_data, o_left, o_valid, o_last stable) until transfer.
- len=0: single beat; o_last=1 on the first beat.
- len=2^SW-1: all shift amounts visited exactly once, starting at i_cmd_shift with wrap.
- i_cmd_valid while in RUN is ignored; o_cmd_ready=0 there, and the upstream must hold its command.
- o_left/o_data in IDLE: retain the last command's values; they are don't-care to the consumer when o_valid=0.
- Reset mid-RUN: next cycle in IDLE with all outputs at reset values. The command is discarded with no o_last pulse.
- Reset has priority over simultaneous i_cmd_valid.
- All outputs are registered; there is no combinational path from i_ready or i_cmd_valid to any output.

Test Plan:
- Reset: hold i_rst=1 for 2 cycles with i_cmd_valid=1 -> o_cmd_ready=1, o_valid=0, o_shift=0, no command accepted.
- Single beat: cmd data=4'b1011, left=1, shift=2, len=0, i_ready=1 -> one cycle later, one beat with o_shift=2, o_last=1, o_data=4'b1011, o_left=1; o_cmd_ready=1 on the following cycle.
- Full sweep with wrap: data=4'b0110, left=0, shift=3, len=3, i_ready=1 -> 4 consecutive beats with o_shift 3,0,1,2; o_last only on the 4th beat.
- Backpressure: len=2, shift=0; drop i_ready for 3 cycles on beat 1 -> o_shift stays 1 and o_valid stays 1 through the stall; the sequence 0,1,2 completes with no beat lost or repeated.
- Command during RUN: assert i_cmd_valid with new data mid-sequence -> ignored (o_cmd_ready=0), o_data unchanged; after the o_last transfer plus one cycle, the new command is accepted.
- Mid-run reset: len=3; assert i_rst after beat 1 -> next cycle o_valid=0, o_last=0, o_shift=0, o_cmd_ready=1; a subsequent command sequences correctly from its own start shift.
